board_seed_loader: RTL and testbench
====================================

# board_seed_loader

Upstream feeder for the Game-of-Life board. It receives a serial pattern stream on three `uio_in` pins (SPI mode 0: `cs_n`, `sclk`, `mosi`), resynchronises it into the `clk` domain and packs it into bytes of 8 cells. It buffers the bytes in a small FIFO and writes them into the board through a valid/ready write port. The simulation controller services that port in its idle state and holds off updates while `load_active` is high.

## Interface
Parameters:
- `LOG_WIDTH`, 6: log2 board columns.
- `LOG_HEIGHT`, 5: log2 board rows.
- `FIFO_DEPTH`, 4: byte FIFO entries (power of two, ≥2).
- `SYNC_STAGES`, 2: flops per input synchroniser (≥2).

Ports:
- `clk`  in  1: system clock (24 MHz).
- `rst_n`  in  1: reset, asynchronous, active-low.
- `spi_cs_n`  in  1: session select, asynchronous to `clk`, active-low.
- `spi_sclk`  in  1: serial clock, asynchronous, ≤ `clk`/8.
- `spi_mosi`  in  1: serial data, asynchronous, MSB first.
- `wr_valid`  out  1: write request to board.
- `wr_ready`  in  1: board accepts write.
- `wr_addr`  out  LOG_WIDTH+LOG_HEIGHT-3: byte address (8-cell group).
- `wr_data`  out  8: cells. `wr_data[7]` maps to cell `{wr_addr,3'd0}`, `wr_data[0]` maps to `{wr_addr,3'd7}`.
- `load_active`  out  1: a session is in progress or the FIFO is draining.
- `load_done`  out  1: one-cycle pulse when a session has fully drained.
- `overflow`  out  1: sticky flag, a byte was dropped this session.

## Operation
- Reset values: every output is 0. Synchronisers reset to `cs_n`=1, `sclk`=0.
- Synchronised `cs_n` falling edge starts a session:
  - bit counter, byte address and `overflow` clear;
  - `load_active` sets.
- `sclk` rising edge with `cs_n` low shifts `mosi` into an 8-bit shift register. The first received bit lands in `wr_data[7]`.
- The 8th bit completes a byte, which is pushed as {address, data}. The byte address then increments.
- Addresses are `0 .. 2^(LOG_WIDTH+LOG_HEIGHT-3)-1` (256 by default). Bytes past the last address are discarded, not wrapped, and set `overflow`.
- A push into a full FIFO drops the byte and sets `overflow`. A push and a pop in the same cycle while full both succeed.
- Synchronised `cs_n` rising edge ends the session:
  - a partial byte is discarded;
  - the FSM waits until the FIFO is empty.
- State machine:
  - IDLE → RECV on `cs_n` fall.
  - RECV → DRAIN on `cs_n` rise.
  - DRAIN → IDLE when the FIFO is empty. `load_done` pulses on this transition and `load_active` clears.
  - A new `cs_n` fall in DRAIN goes directly to RECV. The remaining bytes keep draining, but the address resets to 0.
- `wr_valid` equals FIFO non-empty (first-word fall-through). `wr_addr`/`wr_data` hold stable while `wr_valid & !wr_ready`. A transfer occurs on the edge where both are high.
- `overflow` holds until the next session start or reset.

## Timing
- Edge detection adds 1 cycle after `SYNC_STAGES`. Pin `sclk` rise → shift-register update: `SYNC_STAGES`+1 cycles.
- 8th `sclk` rise → `wr_valid` high: `SYNC_STAGES`+2 cycles, ±1 for metastability.
- Pin `cs_n` rise, FIFO empty and no byte pending → `load_done`: `SYNC_STAGES`+2 cycles.
- Throughput: one write per cycle while `wr_ready` is held high.
- Reset mid-session: asynchronous clear, FIFO emptied, nothing written.
  - If `cs_n` is held low through reset, a falling edge is seen after release and a new session starts at address 0.

## Structure
- Package `seed_pkg`:
  - `LOG_WIDTH`/`LOG_HEIGHT` defaults;
  - `BOARD_BYTES`;
  - state enum {IDLE, RECV, DRAIN};
  - write-entry struct {addr, data}.
- Sub-module `seed_fifo`: synchronous FWFT FIFO, parameterised by depth and width, with full/empty flags and simultaneous push/pop support.
- Top-level hook-up: `uio_in[0]`=`cs_n`, `uio_in[1]`=`sclk`, `uio_in[2]`=`mosi`.
  - The board write port takes priority over INIT/COPY only in ACTION_IDLE.
  - `load_active` gates the update timer.

## Test plan
- Send one session of bytes 0xA5, 0x3C with `wr_ready`=1 → writes (0,0xA5), (1,0x3C); `load_done` pulses once; `overflow`=0.
- Send 256 bytes of 0xFF followed by 2 extra bytes → 256 writes at addresses 0..255; `overflow`=1 after the 257th byte; `load_done` pulses.
- Hold `wr_ready`=0 and send 6 bytes with `FIFO_DEPTH`=4 → bytes 5 and 6 dropped, `overflow`=1. Then release `wr_ready` → exactly 4 writes at addresses 0..3, data stable while stalled.
- Raise `cs_n` after 13 bits (1 byte 0x81 plus 5 bits) → one write (0,0x81), partial byte dropped, `load_done` pulses.
- Assert `rst_n`=0 mid-byte while `wr_valid`=1 → all outputs 0 immediately; after release with `cs_n` high, no writes occur.
- Start a new session while 3 bytes are still draining → the old bytes write at their original addresses, then new bytes start at address 0; one `load_done` after the second session.

Source files
------------

// File: rtl/seed_pkg.sv
// Shared types and defaults for the board seed loader: board geometry,
// loader state encoding and the {address, data} write entry.
package seed_pkg;

    localparam int DEF_LOG_WIDTH  = 6;
    localparam int DEF_LOG_HEIGHT = 5;

    // Number of 8-cell byte groups on a board of the given geometry.
    function automatic int board_bytes(input int log_width, input int log_height);
        return 1 << (log_width + log_height - 3);
    endfunction

    localparam int BOARD_BYTES = board_bytes(DEF_LOG_WIDTH, DEF_LOG_HEIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } seed_state_e;

    // Write entry for the default board geometry; the top level declares its
    // own parameter-sized equivalent.
    typedef struct packed {
        logic [DEF_LOG_WIDTH+DEF_LOG_HEIGHT-4:0] addr;
        logic [7:0]                              data;
    } seed_entry_t;

endpackage

// File: rtl/seed_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// pop_data_o whenever the FIFO is not empty and reads as zero when empty.
// A push and a pop in the same cycle both succeed, even when full.
module seed_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty can be told apart.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[PW-1:0]];

    // Advance each pointer on an accepted push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
        end
    end

    // Pointer registers; clearing them empties the FIFO on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are only observable through a valid pointer.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/board_seed_loader.sv
// Receives a serial Game-of-Life pattern over an SPI mode 0 link, packs it
// into bytes of 8 cells with sequential byte addresses, buffers them in a
// small FIFO and presents them on a valid/ready board write port.
module board_seed_loader
    import seed_pkg::*;
#(
    parameter int LOG_WIDTH   = DEF_LOG_WIDTH,
    parameter int LOG_HEIGHT  = DEF_LOG_HEIGHT,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            spi_cs_n,
    input  logic                            spi_sclk,
    input  logic                            spi_mosi,
    output logic                            wr_valid,
    input  logic                            wr_ready,
    output logic [LOG_WIDTH+LOG_HEIGHT-4:0] wr_addr,
    output logic [7:0]                      wr_data,
    output logic                            load_active,
    output logic                            load_done,
    output logic                            overflow
);

    localparam int ADDR_W = LOG_WIDTH + LOG_HEIGHT - 3;
    localparam logic [ADDR_W:0] ADDR_END = (ADDR_W+1)'(board_bytes(LOG_WIDTH, LOG_HEIGHT));

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } entry_t;

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   cs_prev_q;
    logic                   sclk_prev_q;
    logic                   cs_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sclk_rise;

    seed_state_e            state_q, state_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [ADDR_W:0]        addr_q, addr_d;
    logic                   pend_valid_q, pend_valid_d;
    entry_t                 pend_q, pend_d;
    logic                   overflow_q, overflow_d;
    logic                   load_done_q, load_done_d;

    entry_t                 head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_drop;
    logic                   past_end;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    // Once the address reaches the end of the board it stops counting, so
    // every later byte of the session lands here and is discarded.
    assign past_end = (addr_q == ADDR_END);

    // A pending byte meeting a full FIFO is lost unless the board frees a
    // slot in the same cycle.
    assign fifo_drop = pend_valid_q & fifo_full & ~wr_ready;

    // Resynchronise the pins into clk and keep one delayed copy for edges.
    // The idle levels (deselected, clock low) are the reset values so that a
    // chip select held low through reset reads as a fresh session start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    // Session control: IDLE waits for a select, RECV collects bytes, DRAIN
    // waits for the FIFO and pending byte to empty before signalling done.
    always_comb begin
        state_d     = state_q;
        load_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (cs_rise) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cs_fall) begin
                    state_d = RECV;
                end else if (fifo_empty && !pend_valid_q) begin
                    state_d     = IDLE;
                    load_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bit assembly and byte addressing. The byte is staged in a pending
    // register for one cycle before entering the FIFO. A session start
    // clears the counters and the sticky overflow; a session end throws away
    // any partially received byte.
    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        addr_d       = addr_q;
        pend_valid_d = 1'b0;
        pend_d       = pend_q;
        overflow_d   = overflow_q;

        if (cs_fall) begin
            bit_cnt_d  = 3'd0;
            addr_d     = '0;
            overflow_d = 1'b0;
        end else begin
            if (cs_rise) begin
                bit_cnt_d = 3'd0;
            end else if (sclk_rise && !cs_s && state_q == RECV) begin
                shift_d   = {shift_q[6:0], mosi_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (past_end) begin
                        overflow_d = 1'b1;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_d.addr  = addr_q[ADDR_W-1:0];
                        pend_d.data  = {shift_q[6:0], mosi_s};
                        addr_d       = addr_q + (ADDR_W+1)'(1);
                    end
                end
            end
            if (fifo_drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Session and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            addr_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            overflow_q   <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_q       <= addr_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            overflow_q   <= overflow_d;
            load_done_q  <= load_done_d;
        end
    end

    seed_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + 8)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (pend_valid_q),
        .push_data_i (pend_q),
        .pop_i       (wr_ready),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign wr_valid    = ~fifo_empty;
    assign wr_addr     = head.addr;
    assign wr_data     = head.data;
    assign load_active = (state_q != IDLE);
    assign load_done   = load_done_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_board_seed_loader.sv
// Directed bench for board_seed_loader: drives SPI sessions and keeps a
// queue of the writes the board must receive, checked on every cycle.
module tb_board_seed_loader;

    localparam int LW    = 6;
    localparam int LH    = 5;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int NB    = 1 << (LW + LH - 3);
    localparam int BIG   = 1 << 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       wr_ready = 1'b0;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       load_active;
    logic       load_done;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    logic [15:0] expQ[$];
    int         writeCount = 0;
    int         doneCount = 0;
    int         sessIdx = 0;
    int         modelCap = BIG;
    logic [7:0] lastAddr = 8'h00;
    logic [7:0] lastData = 8'h00;
    time        lastRise = 0;
    bit         measureLat = 1'b0;
    bit         prevValid = 1'b0;
    bit         prevStall = 1'b0;
    logic [7:0] prevAddr = 8'h00;
    logic [7:0] prevData = 8'h00;
    int         lat;
    logic [15:0] e;
    int         wc0;
    int         dc0;

    always #5 clk = ~clk;

    board_seed_loader #(
        .LOG_WIDTH   (LW),
        .LOG_HEIGHT  (LH),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .load_active (load_active),
        .load_done   (load_done),
        .overflow    (overflow)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic startSession();
        spi_cs_n = 1'b0;
        sessIdx  = 0;
        waitClk(4);
    endtask

    task automatic endSession();
        waitClk(4);
        spi_cs_n = 1'b1;
    endtask

    // Sends the top nbits of value MSB first. A full byte is entered into
    // the expected-write model at the moment of its 8th clock rise: it is
    // written at the next session address unless it lies past the board end
    // or beyond what the stalled FIFO can hold.
    task automatic applyStimulus(input logic [7:0] value, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = value[7-i];
            waitClk(4);
            spi_sclk = 1'b1;
            if (i == 7) begin
                lastRise = $time;
                if (sessIdx < NB && sessIdx < modelCap) begin
                    expQ.push_back({8'(sessIdx), value});
                end
                sessIdx++;
            end
            waitClk(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((load_active || expQ.size() != 0) && n < 3000) begin
            waitClk(1);
            n++;
        end
        if (n >= 3000) begin
            checkOutput(name, 32'd0, 32'd1);
        end
        waitClk(3);
    endtask

    // Cycle-by-cycle comparison against the expected-write queue, plus the
    // handshake hold rule and the byte-to-valid latency window.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid = 1'b0;
            prevStall = 1'b0;
        end else begin
            if (load_done) begin
                doneCount++;
            end
            if (prevStall) begin
                checkOutput("stall_valid_held", 32'(wr_valid), 32'd1);
                checkOutput("stall_addr_stable", 32'(wr_addr), 32'(prevAddr));
                checkOutput("stall_data_stable", 32'(wr_data), 32'(prevData));
            end
            if (wr_valid && !prevValid && measureLat) begin
                lat = int'(($time - lastRise) / 10);
                checkOutput("byte_latency_window",
                            32'((lat >= SYNC + 1) && (lat <= SYNC + 3)), 32'd1);
            end
            if (wr_valid && wr_ready) begin
                writeCount++;
                lastAddr = wr_addr;
                lastData = wr_data;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("write_addr", 32'(wr_addr), 32'(e[15:8]));
                    checkOutput("write_data", 32'(wr_data), 32'(e[7:0]));
                end
            end
            prevValid = wr_valid;
            prevStall = wr_valid && !wr_ready;
            prevAddr  = wr_addr;
            prevData  = wr_data;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        #3;
        checkOutput("rst_wr_valid", 32'(wr_valid), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
        checkOutput("rst_load_active", 32'(load_active), 32'd0);
        checkOutput("rst_load_done", 32'(load_done), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        waitClk(3);
        rst_n = 1'b1;
        waitClk(5);
        checkOutput("post_rst_load_active", 32'(load_active), 32'd0);

        // Two bytes, board always ready
        $display("[TB] session: A5 3C");
        wr_ready   = 1'b1;
        measureLat = 1'b1;
        wc0 = writeCount;
        dc0 = doneCount;
        startSession();
        applyStimulus(8'hA5, 8);
        checkOutput("t1_load_active", 32'(load_active), 32'd1);
        applyStimulus(8'h3C, 8);
        endSession();
        waitIdle("t1_drain_timeout");
        measureLat = 1'b0;
        checkOutput("t1_writes", 32'(writeCount - wc0), 32'd2);
        checkOutput("t1_last_addr", 32'(lastAddr), 32'd1);
        checkOutput("t1_last_data", 32'(lastData), 32'h3C);
        checkOutput("t1_done_pulses", 32'(doneCount - dc0), 32'd1);
        checkOutput("t1_overflow", 32'(overflow), 32'd0);

        // Full board plus two extra bytes
        $display("[TB] session: 258 x FF");
        wc0 = writeCount;
        dc0 = doneCount;
        startSession();
        for (int i = 0; i < NB + 2; i++) begin
            applyStimulus(8'hFF, 8);
            if (i == NB - 1) begin
                waitClk(6);
                checkOutput("t2_overflow_at_last", 32'(overflow), 32'd0);
            end
            if (i == NB) begin
                waitClk(6);
                checkOutput("t2_overflow_after_extra", 32'(overflow), 32'd1);
            end
        end
        endSession();
        waitIdle("t2_drain_timeout");
        checkOutput("t2_writes", 32'(writeCount - wc0), 32'd256);
        checkOutput("t2_last_addr", 32'(lastAddr), 32'd255);
        checkOutput("t2_done_pulses", 32'(doneCount - dc0), 32'd1);
        checkOutput("t2_overflow_held", 32'(overflow), 32'd1);

        // Stalled board: FIFO fills and the last two bytes are lost
        $display("[TB] session: 6 bytes into stalled port");
        wr_ready = 1'b0;
        modelCap = DEPTH;
        wc0 = writeCount;
        dc0 = doneCount;
        startSession();
        applyStimulus(8'h11, 8);
        applyStimulus(8'h22, 8);
        applyStimulus(8'h33, 8);
        applyStimulus(8'h44, 8);
        applyStimulus(8'h55, 8);
        applyStimulus(8'h66, 8);
        waitClk(6);
        checkOutput("t3_overflow", 32'(overflow), 32'd1);
        checkOutput("t3_valid_stalled", 32'(wr_valid), 32'd1);
        checkOutput("t3_head_addr", 32'(wr_addr), 32'd0);
        checkOutput("t3_head_data", 32'(wr_data), 32'h11);
        wr_ready = 1'b1;
        endSession();
        waitIdle("t3_drain_timeout");
        modelCap = BIG;
        checkOutput("t3_writes", 32'(writeCount - wc0), 32'd4);
        checkOutput("t3_last_addr", 32'(lastAddr), 32'd3);
        checkOutput("t3_last_data", 32'(lastData), 32'h44);
        checkOutput("t3_done_pulses", 32'(doneCount - dc0), 32'd1);

        // One byte plus a 5-bit fragment
        $display("[TB] session: 81 + 5 bits");
        wc0 = writeCount;
        dc0 = doneCount;
        startSession();
        applyStimulus(8'h81, 8);
        applyStimulus(8'b1011_0000, 5);
        endSession();
        waitIdle("t4_drain_timeout");
        checkOutput("t4_writes", 32'(writeCount - wc0), 32'd1);
        checkOutput("t4_last_addr", 32'(lastAddr), 32'd0);
        checkOutput("t4_last_data", 32'(lastData), 32'h81);
        checkOutput("t4_overflow_cleared", 32'(overflow), 32'd0);
        checkOutput("t4_done_pulses", 32'(doneCount - dc0), 32'd1);

        // New session while three old bytes are still waiting
        $display("[TB] back-to-back sessions during drain");
        wr_ready = 1'b0;
        wc0 = writeCount;
        dc0 = doneCount;
        startSession();
        applyStimulus(8'hC1, 8);
        applyStimulus(8'hC2, 8);
        applyStimulus(8'hC3, 8);
        endSession();
        waitClk(10);
        checkOutput("t6_draining_active", 32'(load_active), 32'd1);
        checkOutput("t6_no_early_done", 32'(doneCount - dc0), 32'd0);
        startSession();
        wr_ready = 1'b1;
        applyStimulus(8'hD1, 8);
        applyStimulus(8'hD2, 8);
        endSession();
        waitIdle("t6_drain_timeout");
        checkOutput("t6_writes", 32'(writeCount - wc0), 32'd5);
        checkOutput("t6_last_addr", 32'(lastAddr), 32'd1);
        checkOutput("t6_last_data", 32'(lastData), 32'hD2);
        checkOutput("t6_done_pulses", 32'(doneCount - dc0), 32'd1);

        // Reset in the middle of a byte with a write pending
        $display("[TB] reset mid-session");
        wr_ready = 1'b0;
        startSession();
        applyStimulus(8'h5A, 8);
        applyStimulus(8'hF0, 4);
        checkOutput("t5_valid_before_reset", 32'(wr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_wr_valid", 32'(wr_valid), 32'd0);
        checkOutput("t5_rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("t5_rst_wr_data", 32'(wr_data), 32'd0);
        checkOutput("t5_rst_load_active", 32'(load_active), 32'd0);
        checkOutput("t5_rst_overflow", 32'(overflow), 32'd0);
        expQ.delete();
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        wc0 = writeCount;
        dc0 = doneCount;
        waitClk(3);
        rst_n    = 1'b1;
        wr_ready = 1'b1;
        waitClk(60);
        checkOutput("t5_no_writes", 32'(writeCount - wc0), 32'd0);
        checkOutput("t5_idle_after", 32'(load_active), 32'd0);
        checkOutput("t5_no_done", 32'(doneCount - dc0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
